tx_shift_engine: RTL and testbench

//  UART transmit engine downstream of the Tx parity generator. Latches a byte on
//  a write strobe and drives it to the parity generator as load_data. Takes the

---
 rtl/uart_pkg.sv | 69 ++++++
 rtl/tx_baud_gen.sv | 53 +++++
 rtl/tx_shift_engine.sv | 179 +++++++++++++++++
 tb/tb_tx_shift_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path:
//   - frame geometry (bits per frame, bit counter width)
//   - baud divider width and a divider table for a 100 MHz system clock
//   - transmit engine state encoding
//   - frame assembly helper used when the shift register is armed
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_BAUD_W    = 19;
    localparam int unsigned UART_FRAME_N   = 11;
    localparam int unsigned UART_BIT_CNT_W = 4;

    // Transmit engine control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARM   = 2'b01,
        ST_SHIFT = 2'b10
    } tx_state_e;

    // Supported line rates
    typedef enum logic [3:0] {
        BAUD_300    = 4'd0,
        BAUD_1200   = 4'd1,
        BAUD_2400   = 4'd2,
        BAUD_4800   = 4'd3,
        BAUD_9600   = 4'd4,
        BAUD_19200  = 4'd5,
        BAUD_38400  = 4'd6,
        BAUD_57600  = 4'd7,
        BAUD_115200 = 4'd8,
        BAUD_230400 = 4'd9,
        BAUD_460800 = 4'd10,
        BAUD_921600 = 4'd11
    } baud_sel_e;

    // Clocks-per-bit minus one at 100 MHz, rounded down to the nearest clock
    function automatic logic [UART_BAUD_W-1:0] baud_k_for(input baud_sel_e sel);
        logic [UART_BAUD_W-1:0] k_v;
        case (sel)
            BAUD_300:    k_v = 19'd333332;
            BAUD_1200:   k_v = 19'd83332;
            BAUD_2400:   k_v = 19'd41665;
            BAUD_4800:   k_v = 19'd20832;
            BAUD_9600:   k_v = 19'd10415;
            BAUD_19200:  k_v = 19'd5207;
            BAUD_38400:  k_v = 19'd2603;
            BAUD_57600:  k_v = 19'd1735;
            BAUD_115200: k_v = 19'd867;
            BAUD_230400: k_v = 19'd433;
            BAUD_460800: k_v = 19'd216;
            BAUD_921600: k_v = 19'd107;
            default:     k_v = 19'd867;
        endcase
        return k_v;
    endfunction

    // Frame image with bit 0 leaving first: leading idle 1, start 0,
    // d0..d6, then the two parity-generator bits.
    function automatic logic [UART_FRAME_N-1:0] build_frame(
        input logic       b10,
        input logic       b9,
        input logic [6:0] data
    );
        return {b10, b9, data, 1'b0, 1'b1};
    endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// ---------------------------------------------------------------------------
// tx_baud_gen
// Bit-time generator for the transmit engine. Counts clocks while doit is
// high and flags btu on the last clock of each bit time. The counter is held
// at zero whenever doit is low, so every frame starts on a fresh bit time.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   doit     in   engine is shifting a frame
//   baud_k   in   clocks per bit minus one
//   btu      out  bit-time up: last clock of the current bit
// ---------------------------------------------------------------------------
module tx_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_W = UART_BAUD_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              doit,
    input  logic [BAUD_W-1:0] baud_k,
    output logic              btu
);

    logic [BAUD_W-1:0] baud_cnt_r;
    logic              btu_s;

    // Terminal count; >= keeps the counter bounded even if baud_k shrinks
    always_comb begin
        btu_s = 1'b0;
        if (doit && (baud_cnt_r >= baud_k)) begin
            btu_s = 1'b1;
        end else begin
            btu_s = 1'b0;
        end
    end

    // Bit-time counter: cleared when idle and on every bit boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
        end else if (!doit) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
        end else if (btu_s) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
        end else begin
            baud_cnt_r <= baud_cnt_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
    end

    assign btu = btu_s;

endmodule

// File: rtl/tx_shift_engine.sv
// ---------------------------------------------------------------------------
// tx_shift_engine
// UART transmit engine. Latches a byte on load, presents it to the parity
// generator as load_data, waits one cycle (ARM) for bit9/bit10 to settle,
// then freezes the 11-bit frame into a shift register and sends it LSB-first
// at baud_k+1 clocks per bit.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset (aborts a frame in flight)
//   load       in   one-cycle write strobe; accepted only while tx_rdy=1
//   out_port   in   byte to transmit, valid with load
//   baud_k     in   clocks per bit minus one, static during a frame
//   bit10      in   parity generator bit 10 (parity or stop)
//   bit9       in   parity generator bit 9 (d7, parity or stop)
//   load_data  out  latched byte toward the parity generator
//   tx         out  serial line, idle high
//   tx_rdy     out  engine idle, next load will be taken
//   tx_done    out  one-cycle pulse when the last bit time ends
// ---------------------------------------------------------------------------
module tx_shift_engine
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_W  = UART_BAUD_W,
    parameter int unsigned FRAME_N = UART_FRAME_N
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [7:0]        out_port,
    input  logic [BAUD_W-1:0] baud_k,
    input  logic              bit10,
    input  logic              bit9,
    output logic [7:0]        load_data,
    output logic              tx,
    output logic              tx_rdy,
    output logic              tx_done
);

    localparam logic [UART_BIT_CNT_W-1:0] LAST_BIT = UART_BIT_CNT_W'(FRAME_N - 1);
    localparam logic [UART_BIT_CNT_W-1:0] BIT_ONE  = UART_BIT_CNT_W'(1);

    tx_state_e                   state_r;
    tx_state_e                   state_nxt_s;
    logic [7:0]                  load_data_r;
    logic [FRAME_N-1:0]          sr_r;
    logic [UART_BIT_CNT_W-1:0]   bit_cnt_r;
    logic                        doit_r;
    logic                        load_d_r;
    logic                        tx_rdy_r;
    logic                        tx_done_r;
    logic                        btu_s;
    logic                        accept_s;
    logic                        arm_s;
    logic                        shift_s;
    logic                        frame_end_s;
    logic                        recover_s;

    tx_baud_gen #(
        .BAUD_W (BAUD_W)
    ) u_baud_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .doit    (doit_r),
        .baud_k  (baud_k),
        .btu     (btu_s)
    );

    // Control state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle action strobes
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        arm_s       = 1'b0;
        shift_s     = 1'b0;
        frame_end_s = 1'b0;
        recover_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                // ARM is only legal right after an accepted load
                if (load_d_r) begin
                    arm_s       = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    recover_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (btu_s) begin
                    shift_s = 1'b1;
                    if (bit_cnt_r == LAST_BIT) begin
                        frame_end_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                recover_s   = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Byte latch toward the parity generator; untouched while busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_data_r <= 8'h00;
        end else if (accept_s) begin
            load_data_r <= out_port;
        end
    end

    // CPU-side handshake flags and the one-cycle ARM marker
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_rdy_r  <= 1'b1;
            tx_done_r <= 1'b0;
            load_d_r  <= 1'b0;
        end else begin
            tx_done_r <= frame_end_s;
            load_d_r  <= accept_s;
            if (accept_s) begin
                tx_rdy_r <= 1'b0;
            end else if (frame_end_s || recover_s) begin
                tx_rdy_r <= 1'b1;
            end
        end
    end

    // Frame shift register, bit counter and shift enable. bit9/bit10 are
    // sampled only at ARM, so later changes cannot disturb the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_r      <= {FRAME_N{1'b1}};
            bit_cnt_r <= {UART_BIT_CNT_W{1'b0}};
            doit_r    <= 1'b0;
        end else if (arm_s) begin
            sr_r      <= build_frame(bit10, bit9, load_data_r[6:0]);
            bit_cnt_r <= {UART_BIT_CNT_W{1'b0}};
            doit_r    <= 1'b1;
        end else if (shift_s) begin
            // Ones fill from the top so the line idles high after the frame
            sr_r      <= {1'b1, sr_r[FRAME_N-1:1]};
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
            if (frame_end_s) begin
                doit_r <= 1'b0;
            end
        end else if (recover_s) begin
            sr_r   <= {FRAME_N{1'b1}};
            doit_r <= 1'b0;
        end
    end

    assign load_data = load_data_r;
    assign tx        = sr_r[0];
    assign tx_rdy    = tx_rdy_r;
    assign tx_done   = tx_done_r;

endmodule

// File: tb/tb_tx_shift_engine.sv
// ---------------------------------------------------------------------------
// tb_tx_shift_engine
// Directed and randomized checks of the UART transmit engine against a
// line-level model: each frame is the list 1, 0, d0..d6, bit9, bit10, every
// entry held for baud_k+1 clocks starting at the cycle after the ARM edge.
// ---------------------------------------------------------------------------
module tb_tx_shift_engine;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [7:0]  out_port;
    logic [18:0] baud_k;
    logic        bit10;
    logic        bit9;
    logic [7:0]  load_data;
    logic        tx;
    logic        tx_rdy;
    logic        tx_done;

    int checks;
    int failures;
    logic exp_q[$];

    tx_shift_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .out_port  (out_port),
        .baud_k    (baud_k),
        .bit10     (bit10),
        .bit9      (bit9),
        .load_data (load_data),
        .tx        (tx),
        .tx_rdy    (tx_rdy),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected per-clock line values for one frame
    task automatic model_frame(input logic [7:0] d, input logic b9, input logic b10, input int k);
        logic line [11];
        line[0] = 1'b1;
        line[1] = 1'b0;
        for (int i = 0; i < 7; i++) line[2+i] = d[i];
        line[9]  = b9;
        line[10] = b10;
        exp_q.delete();
        for (int b = 0; b < 11; b++)
            for (int c = 0; c <= k; c++) exp_q.push_back(line[b]);
    endtask

    // Present a byte: called #1 after a posedge while the engine is idle
    task automatic start(input logic [7:0] d);
        load     = 1'b1;
        out_port = d;
    endtask

    // Bounded wait for the engine to be idle; returns #1 after a posedge
    task automatic wait_rdy();
        int n = 0;
        @(posedge clk); #1;
        while (tx_rdy !== 1'b1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_rdy", tx_rdy, 1);
    endtask

    // Follow one frame from its load edge E0 to the tx_done cycle.
    // load must already be high. busy_at>=0 pulses a stray load mid-frame.
    task automatic frame(input logic [7:0] d, input logic b9, input logic b10,
                         input int busy_at, input bit load_next, input logic [7:0] nd);
        int n;
        bit9  = b9;
        bit10 = b10;
        model_frame(d, b9, b10, int'(baud_k));
        n = exp_q.size();
        @(posedge clk);            // E0
        #1 load = 1'b0;
        @(negedge clk);
        check("e0_load_data", load_data, d);
        check("e0_rdy", tx_rdy, 0);
        check("e0_done", tx_done, 0);
        check("e0_tx", tx, 1);
        @(posedge clk);            // E1: frame image frozen
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            check("tx_bit", tx, exp_q[t]);
            check("busy_rdy", tx_rdy, 0);
            check("busy_done", tx_done, 0);
            @(posedge clk);
            if (t < n - 1) begin
                #1;
                bit9  = 1'($urandom);
                bit10 = 1'($urandom);
                if (t == busy_at) begin
                    load     = 1'b1;
                    out_port = 8'h55;
                end else begin
                    load = 1'b0;
                end
            end
        end
        if (load_next) begin
            #1;
            load     = 1'b1;
            out_port = nd;
        end
        @(negedge clk);
        check("end_rdy", tx_rdy, 1);
        check("end_done", tx_done, 1);
        check("end_tx", tx, 1);
        check("end_load_data", load_data, d);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] d2;
        logic       b9;
        logic       b10;
        int         busy;
        int         ks [5];
        checks   = 0;
        failures = 0;
        ks[0] = 0; ks[1] = 1; ks[2] = 2; ks[3] = 3; ks[4] = 5;

        reset_n  = 1'b0;
        load     = 1'b0;
        out_port = 8'h00;
        baud_k   = 19'd3;
        bit9     = 1'b0;
        bit10    = 1'b0;

        // Reset state
        #12;
        check("rst_tx", tx, 1);
        check("rst_rdy", tx_rdy, 1);
        check("rst_done", tx_done, 0);
        check("rst_load_data", load_data, 0);
        reset_n = 1'b1;

        // 8N1 0xA5
        @(posedge clk); #1;
        start(8'hA5);
        frame(8'hA5, 1'b1, 1'b1, -1, 1'b0, 8'h00);

        // 7E1 0x41 with a stray load while busy
        wait_rdy();
        start(8'h41);
        frame(8'h41, 1'b0, 1'b1, 9, 1'b0, 8'h00);

        // Back-to-back frames at one clock per bit
        baud_k = 19'd0;
        wait_rdy();
        start(8'h3C);
        frame(8'h3C, 1'b1, 1'b0, -1, 1'b1, 8'hC6);
        frame(8'hC6, 1'b0, 1'b1, -1, 1'b0, 8'h00);

        // Reset during bit 5 (d3 = 0) of a frame
        baud_k = 19'd3;
        wait_rdy();
        start(8'hC3);
        bit9 = 1'b1; bit10 = 1'b1;
        @(posedge clk);            // E0
        #1 load = 1'b0;
        @(posedge clk);            // E1
        repeat (21) @(posedge clk);
        #2;
        check("pre_rst_tx", tx, 0);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_rdy", tx_rdy, 1);
        check("mid_rst_done", tx_done, 0);
        check("mid_rst_load_data", load_data, 0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_rdy", tx_rdy, 1);
        check("post_rst_tx", tx, 1);
        start(8'h96);
        frame(8'h96, 1'b1, 1'b0, -1, 1'b0, 8'h00);

        // Randomized frames
        for (int i = 0; i < 10; i++) begin
            baud_k = 19'(ks[$urandom_range(0, 4)]);
            d   = 8'($urandom);
            d2  = 8'($urandom);
            b9  = 1'($urandom);
            b10 = 1'($urandom);
            busy = ($urandom_range(0, 1) == 0) ? -1
                 : int'($urandom_range(0, 11 * (int'(baud_k) + 1) - 3));
            wait_rdy();
            start(d);
            if (i % 3 == 0) begin
                frame(d, b9, b10, busy, 1'b1, d2);
                frame(d2, b10, b9, -1, 1'b0, 8'h00);
            end else begin
                frame(d, b9, b10, busy, 1'b0, 8'h00);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
